// File: rtl/dcache_pkg.sv
// Shared geometry, controller state encoding and address helpers for the
// data-cache miss-handling controller.
package dcache_pkg;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int TAG_W    = 18;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 4;
  localparam int BLK_W    = 512;
  localparam int WORDS    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_WB,
    S_FILL,
    S_LOAD
  } dcache_ctrl_state_t;

  // Line address as seen by block memory: {tag, index}.
  function automatic logic [TAG_W+INDEX_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/dcache_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear, used for the
// miss and write-back performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Miss-handling controller for the direct-mapped write-back data cache:
// lookup, dirty-victim write-back, line fill, line load and replay.
module dcache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int TAG_W    = 18,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 4,
  parameter int BLK_W    = 512,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_rd,
  input  logic                     cpu_wr,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_done,
  output logic                     cpu_stall,
  output logic                     c_en,
  output logic                     c_rd,
  output logic                     c_wr,
  output logic                     c_ld,
  output logic [ADDR_W-1:0]        c_addr,
  output logic [31:0]              c_data_in,
  output logic [BLK_W-1:0]         c_blk_in,
  input  logic                     c_hit,
  input  logic                     c_miss,
  input  logic                     c_evict,
  input  logic [31:0]              c_data_out,
  input  logic [BLK_W-1:0]         c_blk_out,
  input  logic [TAG_W-1:0]         c_victim_tag,
  output logic                     mem_rd_req,
  output logic                     mem_wr_req,
  output logic [TAG_W+INDEX_W-1:0] mem_addr,
  output logic [BLK_W-1:0]         mem_wdata,
  input  logic [BLK_W-1:0]         mem_rdata,
  input  logic                     mem_ack,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [CNT_W-1:0]         wb_cnt
);

  import dcache_pkg::*;

  dcache_ctrl_state_t state, state_n;

  logic [ADDR_W-1:0]        req_addr;
  logic [31:0]              req_wdata;
  logic                     req_wr;
  logic [BLK_W-1:0]         line_buf;
  logic [TAG_W+INDEX_W-1:0] victim_addr;
  logic                     miss_inc;
  logic                     wb_inc;
  logic                     lookup_phase;
  logic                     accept;

  assign accept       = (state == S_IDLE) && (cpu_rd || cpu_wr);
  assign lookup_phase = (state == S_LOOKUP) || (state == S_CHECK);

  always_comb begin
    state_n    = state;
    miss_inc   = 1'b0;
    wb_inc     = 1'b0;
    cpu_stall  = (state != S_IDLE);
    c_en       = lookup_phase || (state == S_LOAD);
    c_rd       = lookup_phase && !req_wr;
    c_wr       = lookup_phase && req_wr;
    c_ld       = (state == S_LOAD);
    c_addr     = '0;
    c_data_in  = '0;
    c_blk_in   = '0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    if (c_en)
      c_addr = req_addr;
    if (c_wr)
      c_data_in = req_wdata;

    unique case (state)
      S_IDLE:   if (accept) state_n = S_LOOKUP;
      S_LOOKUP: state_n = S_CHECK;
      S_CHECK: begin
        if (c_hit) begin
          state_n = S_IDLE;
        end else if (c_miss) begin
          miss_inc = 1'b1;
          wb_inc   = c_evict;
          state_n  = c_evict ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        mem_wr_req = 1'b1;
        mem_addr   = victim_addr;
        mem_wdata  = line_buf;
        if (mem_ack) state_n = S_FILL;
      end
      S_FILL: begin
        mem_rd_req = 1'b1;
        mem_addr   = line_addr(req_addr);
        if (mem_ack) state_n = S_LOAD;
      end
      S_LOAD: begin
        c_blk_in = line_buf;
        state_n  = S_LOOKUP;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // One line buffer serves both the victim (WB) and the fill (FILL):
  // write-back always completes before the fill data arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_wr      <= 1'b0;
      line_buf    <= '0;
      victim_addr <= '0;
      cpu_done    <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      state    <= state_n;
      cpu_done <= 1'b0;
      if (accept) begin
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
        req_wr    <= !cpu_rd;
      end
      if (state == S_CHECK) begin
        if (c_hit) begin
          cpu_done  <= 1'b1;
          cpu_rdata <= req_wr ? '0 : c_data_out;
        end else if (c_miss && c_evict) begin
          line_buf    <= c_blk_out;
          victim_addr <= {c_victim_tag, req_addr[OFFSET_W+INDEX_W-1:OFFSET_W]};
        end
      end
      if ((state == S_FILL) && mem_ack)
        line_buf <= mem_rdata;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wb_inc),
    .count (wb_cnt)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a behavioural direct-mapped cache and
// a block memory whose acknowledge latency is set per test step.
module tb_dcache_ctrl;

  localparam logic [511:0] PRE_LINE = {352'h0, 32'h44444444, 32'hDEADBEEF, 96'h0};

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_rd, cpu_wr;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_done, cpu_stall;
  logic         c_en, c_rd, c_wr, c_ld;
  logic [31:0]  c_addr, c_data_in;
  logic [511:0] c_blk_in;
  logic         c_hit, c_miss, c_evict;
  logic [31:0]  c_data_out;
  logic [511:0] c_blk_out;
  logic [17:0]  c_victim_tag;
  logic         mem_rd_req, mem_wr_req;
  logic [27:0]  mem_addr;
  logic [511:0] mem_wdata, mem_rdata;
  logic         mem_ack;
  logic [15:0]  miss_cnt, wb_cnt;

  logic         sc_inc;
  logic [3:0]   sc_count;

  int n_assert = 0;
  int n_fail   = 0;
  int excl_viol = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(
    .ADDR_W(32), .TAG_W(18), .INDEX_W(10), .OFFSET_W(4), .BLK_W(512), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .c_en(c_en), .c_rd(c_rd), .c_wr(c_wr), .c_ld(c_ld),
    .c_addr(c_addr), .c_data_in(c_data_in), .c_blk_in(c_blk_in),
    .c_hit(c_hit), .c_miss(c_miss), .c_evict(c_evict),
    .c_data_out(c_data_out), .c_blk_out(c_blk_out), .c_victim_tag(c_victim_tag),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  sat_counter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .inc(sc_inc), .count(sc_count)
  );

  // Cache model: results registered one cycle after c_en.
  logic [17:0]  ctag   [1024];
  logic         cval   [1024];
  logic         cdirty [1024];
  logic [511:0] cdata  [1024];
  wire  [9:0]   c_idx = c_addr[13:4];
  wire  [3:0]   c_off = c_addr[3:0];
  wire  [17:0]  c_tg  = c_addr[31:14];

  always @(posedge clk) begin
    c_hit   <= 1'b0;
    c_miss  <= 1'b0;
    c_evict <= 1'b0;
    if (rst) begin
      for (int i = 0; i < 1024; i++) begin
        cval[i]   <= 1'b0;
        cdirty[i] <= 1'b0;
      end
      cval[4]  <= 1'b1;
      ctag[4]  <= '0;
      cdata[4] <= PRE_LINE;
    end else if (c_en && c_ld) begin
      cval[c_idx]   <= 1'b1;
      cdirty[c_idx] <= 1'b0;
      ctag[c_idx]   <= c_tg;
      cdata[c_idx]  <= c_blk_in;
    end else if (c_en) begin
      if (cval[c_idx] && (ctag[c_idx] == c_tg)) begin
        c_hit      <= 1'b1;
        c_data_out <= cdata[c_idx][c_off*32 +: 32];
        if (c_wr) begin
          cdata[c_idx][c_off*32 +: 32] <= c_data_in;
          cdirty[c_idx] <= 1'b1;
        end
      end else begin
        c_miss       <= 1'b1;
        c_evict      <= cval[c_idx] && cdirty[c_idx];
        c_blk_out    <= cdata[c_idx];
        c_victim_tag <= ctag[c_idx];
      end
    end
  end

  // Memory model: ack after mem_wait held-request cycles; fill word i = {i, line addr}.
  logic [7:0] mem_wait;
  logic [7:0] mcnt;
  logic       stray_ack;

  assign mem_ack = ((mem_rd_req || mem_wr_req) && (mcnt == mem_wait)) || stray_ack;

  always @(posedge clk) begin
    if (!(mem_rd_req || mem_wr_req) || mem_ack) mcnt <= '0;
    else mcnt <= mcnt + 8'd1;
  end

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem_rdata[i*32 +: 32] = {4'(i), mem_addr};
  end

  always @(negedge clk) begin
    if ((32'(c_rd) + 32'(c_wr) + 32'(c_ld)) > 1 || (mem_rd_req && mem_wr_req))
      excl_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-transaction observations.
  int          n_ld, n_rdreq, n_wrreq, first_op, stray_at;
  logic [31:0] rd_addr, wr_addr, wr_word0;

  task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output int cyc, output logic [31:0] rdata);
    n_ld = 0; n_rdreq = 0; n_wrreq = 0; first_op = 0;
    rd_addr = '0; wr_addr = '0; wr_word0 = '0;
    cyc = -1; rdata = '0;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    for (int m = 1; m <= 200; m++) begin
      @(negedge clk);
      if (m == 1) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
      if (c_ld) n_ld++;
      if (mem_wr_req) begin
        n_wrreq++; wr_addr = 32'(mem_addr); wr_word0 = mem_wdata[31:0];
        if (first_op == 0) first_op = 1;
      end
      if (mem_rd_req) begin
        n_rdreq++; rd_addr = 32'(mem_addr);
        if (first_op == 0) first_op = 2;
      end
      stray_ack = (m == stray_at);
      if (cpu_done) begin cyc = m; rdata = cpu_rdata; break; end
    end
    stray_ack = 1'b0;
  endtask

  int          cyc, ndone, d1, d2, saw;
  logic [31:0] rdata, r1, r2;

  initial begin
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_wait = 8'd0; stray_ack = 1'b0; stray_at = -1; sc_inc = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_done", 32'(cpu_done), 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_cache_ctl", {28'h0, c_en, c_rd, c_wr, c_ld}, 0);
    chk("rst_mem_req", {30'h0, mem_rd_req, mem_wr_req}, 0);
    chk("rst_cnts", {miss_cnt, wb_cnt}, 0);
    rst = 1'b0;

    // Read hit, with a stray ack during LOOKUP
    stray_at = 1;
    xact(1'b1, 1'b0, 32'h0000_0043, '0, cyc, rdata);
    stray_at = -1;
    chk("hit_cycle", cyc, 3);
    chk("hit_rdata", rdata, 32'hDEADBEEF);
    chk("hit_no_mem", n_rdreq + n_wrreq, 0);

    // Clean read miss, ack after 2 wait cycles
    mem_wait = 8'd2;
    xact(1'b1, 1'b0, 32'h1234_5678, '0, cyc, rdata);
    chk("cmiss_cycle", cyc, 9);
    chk("cmiss_rdata", rdata, 32'h81234567);
    chk("cmiss_mem_addr", rd_addr, 32'h0123_4567);
    chk("cmiss_rd_cycles", n_rdreq, 3);
    chk("cmiss_no_wb", n_wrreq, 0);
    chk("cmiss_ld_cycles", n_ld, 1);
    chk("cmiss_cnts", {miss_cnt, wb_cnt}, {16'd1, 16'd0});

    // Write miss (write-allocate), making line 1 dirty
    mem_wait = 8'd0;
    xact(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5A5A5, cyc, rdata);
    chk("wmiss_cycle", cyc, 7);
    chk("wmiss_rdata", rdata, 0);
    chk("wmiss_cnt", miss_cnt, 2);

    // Dirty miss on the same index, rd/wr both high (read wins), 1 wait cycle each
    mem_wait = 8'd1;
    xact(1'b1, 1'b1, 32'h0004_0010, 32'h11111111, cyc, rdata);
    chk("dmiss_cycle", cyc, 10);
    chk("dmiss_first_op_wb", first_op, 1);
    chk("dmiss_wb_addr", wr_addr, 32'h0000_0001);
    chk("dmiss_wb_word0", wr_word0, 32'hA5A5A5A5);
    chk("dmiss_wb_cycles", n_wrreq, 2);
    chk("dmiss_fill_addr", rd_addr, 32'h0000_4001);
    chk("dmiss_rdata", rdata, 32'h00004001);
    chk("dmiss_cnts", {miss_cnt, wb_cnt}, {16'd3, 16'd1});

    // Back-to-back: strobe held while stalled, new request in the done cycle
    mem_wait = 8'd0;
    ndone = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0000_0043;
    for (int m = 1; m <= 12; m++) begin
      @(negedge clk);
      if (cpu_done) begin
        ndone++;
        if (d1 < 0) begin d1 = m; r1 = cpu_rdata; end
        else begin d2 = m; r2 = cpu_rdata; end
      end
      if (m == 3) cpu_addr = 32'h0000_0044;
      if (m == 4) cpu_rd = 1'b0;
    end
    chk("b2b_done_count", ndone, 2);
    chk("b2b_first_cycle", d1, 3);
    chk("b2b_second_cycle", d2, 6);
    chk("b2b_first_rdata", r1, 32'hDEADBEEF);
    chk("b2b_second_rdata", r2, 32'h44444444);
    chk("b2b_miss_cnt", miss_cnt, 3);

    // Reset during a long FILL wait
    mem_wait = 8'd50;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h0008_0000;
    @(negedge clk);
    cpu_rd = 1'b0;
    saw = 0;
    for (int m = 0; m < 20; m++) begin
      if (mem_rd_req) begin saw = 1; break; end
      @(negedge clk);
    end
    chk("rstfill_req_seen", saw, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstfill_rd_req", 32'(mem_rd_req), 0);
    chk("rstfill_stall", 32'(cpu_stall), 0);
    chk("rstfill_cnts", {miss_cnt, wb_cnt}, 0);
    rst = 1'b0;
    mem_wait = 8'd0;
    xact(1'b1, 1'b0, 32'h0000_0043, '0, cyc, rdata);
    chk("after_rst_cycle", cyc, 3);
    chk("after_rst_rdata", rdata, 32'hDEADBEEF);
    chk("after_rst_miss_cnt", miss_cnt, 0);

    // Saturation on a narrow counter instance
    @(negedge clk);
    sc_inc = 1'b1;
    repeat (3) @(negedge clk);
    chk("sat_count3", 32'(sc_count), 3);
    repeat (17) @(negedge clk);
    chk("sat_hold_max", 32'(sc_count), 32'hF);
    sc_inc = 1'b0;
    @(negedge clk);
    chk("sat_idle_hold", 32'(sc_count), 32'hF);

    chk("mutual_exclusion", excl_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
